// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin arbiter sharing one SPI flash; each grant runs a
// READ (0x03) + 24-bit address frame and returns one little-endian 32-bit word.
module spi_flash_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        flash_csb,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_e;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  // DONE is the first gap cycle, so GAP counts down the remaining GAP_CYC-1.
  localparam logic [15:0] GAP_LOAD = (GAP_CYC > 1) ? 16'(GAP_CYC - 2) : 16'd0;

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic        csb_q, csb_d;
  logic        sck_q, sck_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] rx_q, rx_d;
  logic [15:0] gap_q, gap_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic        grant1;
  logic [31:0] word;

  // Port 1 wins when alone, or when both ask and port 0 was served last.
  assign grant1     = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = ~wb_rst_i & (state_q == IDLE) & req0_valid & ~grant1;
  assign req1_ready = ~wb_rst_i & (state_q == IDLE) & grant1;
  assign word       = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

  assign flash_csb  = csb_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = sh_q[31];
  assign busy       = (state_q != IDLE);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_d       = last_q;
    csb_d        = csb_q;
    sck_d        = sck_q;
    div_d        = div_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    rx_d         = rx_q;
    gap_d        = gap_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    unique case (state_q)
      IDLE: if (req0_valid | req1_valid) begin
        state_d = SHIFT;
        port_d  = grant1;
        last_d  = grant1;
        csb_d   = 1'b0;
        sck_d   = 1'b0;
        div_d   = 8'd0;
        bit_d   = 6'd0;
        sh_d    = {8'h03, grant1 ? req1_addr : req0_addr};
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[30:0], flash_miso};
          end else if (bit_q == 6'd63) begin
            state_d = DONE;
            csb_d   = 1'b1;
            if (port_q) begin
              rsp1_valid_d = 1'b1;
              rsp1_data_d  = word;
            end else begin
              rsp0_valid_d = 1'b1;
              rsp0_data_d  = word;
            end
          end else begin
            bit_d = bit_q + 6'd1;
            sh_d  = {sh_q[30:0], 1'b0};
          end
        end
      end
      DONE: begin
        state_d = (GAP_CYC > 1) ? GAP : IDLE;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        if (gap_q == 16'd0) state_d = IDLE;
        else                gap_d   = gap_q - 16'd1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      last_q       <= 1'b1;
      csb_q        <= 1'b1;
      sck_q        <= 1'b0;
      div_q        <= 8'd0;
      bit_q        <= 6'd0;
      sh_q         <= 32'd0;
      rx_q         <= 32'd0;
      gap_q        <= 16'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_q       <= last_d;
      csb_q        <= csb_d;
      sck_q        <= sck_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      rx_q         <= rx_d;
      gap_q        <= gap_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench: three arbiters (CLK_DIV 2/1/4) each with a behavioural
// flash; stimulus pushes expected grants/frames/responses, one monitor checks.
module tb_spi_flash_arbiter;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  r0v = '0, r1v = '0, r0r, r1r, s0v, s1v;
  logic [23:0] r0a [3];
  logic [23:0] r1a [3];
  logic [31:0] s0d [3];
  logic [31:0] s1d [3];
  logic [2:0]  csb, sck, mosi, busy;
  logic [2:0]  miso = '0;
  bit          fin = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_flash_arbiter #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 4)), .GAP_CYC(GAP)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req0_valid(r0v[g]), .req0_addr(r0a[g]), .req0_ready(r0r[g]),
      .rsp0_valid(s0v[g]), .rsp0_data(s0d[g]),
      .req1_valid(r1v[g]), .req1_addr(r1a[g]), .req1_ready(r1r[g]),
      .rsp1_valid(s1v[g]), .rsp1_data(s1d[g]),
      .flash_csb(csb[g]), .flash_sck(sck[g]), .flash_mosi(mosi[g]),
      .flash_miso(miso[g]), .busy(busy[g]));
  end

  // Scoreboard queues: grant {port, back_to_back}, response {port, data},
  // frame {command, csb_low_cycles[15:0], mosi_nonzero_in_data}.
  logic [1:0]  gnt_q [3][$];
  logic [32:0] rsp_q [3][$];
  logic [48:0] frm_q [3][$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int bitcnt [3], lo_len [3], hi_len [3], last_gnt [3];
  logic [31:0] cmd [3];
  bit pcsb [3], psck [3], seen [3], mbad [3], chk_busy [3];
  int dd;
  logic [7:0] bb;
  logic [1:0] ge;
  logic [32:0] re;
  logic [48:0] fe;

  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h000010: return 8'h11;
      24'h000011: return 8'h22;
      24'h000012: return 8'h33;
      24'h000013: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic int cd_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d got=%0h exp=%0h", nm, k, got, exp);
    end
  endtask

  task automatic fail(input string nm, input int k);
    n_tests++;
    n_fail++;
    $display("FAIL %s dut=%0d got=event exp=none", nm, k);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (fin || cyc > 60000) begin
      if (!fin) fail("global_timeout", 0);
      for (int k = 0; k < 3; k++) begin
        chk("gnt_left", k, gnt_q[k].size(), 0);
        chk("rsp_left", k, rsp_q[k].size(), 0);
        chk("frm_left", k, frm_q[k].size(), 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        chk("rst_flags", k, {csb[k], sck[k], mosi[k], r0r[k], r1r[k], s0v[k], s1v[k], busy[k]}, 8'h80);
        chk("rst_data", k, {s0d[k], s1d[k]}, 64'd0);
        pcsb[k] = 1'b1; psck[k] = 1'b0; bitcnt[k] = 0; seen[k] = 1'b0;
        chk_busy[k] = 1'b0; miso[k] = 1'b0;
      end else begin
        if (chk_busy[k]) begin
          chk("busy_after_grant", k, busy[k], 1);
          chk_busy[k] = 1'b0;
        end
        if (r0r[k] || r1r[k]) begin
          if (gnt_q[k].size() == 0) fail("unexpected_grant", k);
          else begin
            ge = gnt_q[k].pop_front();
            chk("grant_port", k, {r1r[k], r0r[k]}, ge[1] ? 2'b10 : 2'b01);
            if (ge[0]) chk("ready_spacing", k, cyc - last_gnt[k], 128 * cd_of(k) + 1 + GAP);
          end
          last_gnt[k] = cyc;
          chk_busy[k] = 1'b1;
        end
        if (s0v[k]) begin
          if (rsp_q[k].size() == 0) fail("unexpected_rsp0", k);
          else begin re = rsp_q[k].pop_front(); chk("rsp0", k, {1'b0, s0d[k]}, re); end
        end
        if (s1v[k]) begin
          if (rsp_q[k].size() == 0) fail("unexpected_rsp1", k);
          else begin re = rsp_q[k].pop_front(); chk("rsp1", k, {1'b1, s1d[k]}, re); end
        end
        // Behavioural flash: command in on SCK rise, data out on SCK fall.
        if (pcsb[k] && !csb[k]) begin
          if (seen[k]) chk("csb_gap_ok", k, (hi_len[k] >= GAP), 1);
          bitcnt[k] = 0; lo_len[k] = 0; cmd[k] = '0; mbad[k] = 1'b0;
        end
        if (!csb[k]) begin
          lo_len[k]++;
          if (!psck[k] && sck[k]) begin
            if (bitcnt[k] < 32) cmd[k] = {cmd[k][30:0], mosi[k]};
            else if (mosi[k]) mbad[k] = 1'b1;
            bitcnt[k]++;
          end
          if (psck[k] && !sck[k] && bitcnt[k] >= 32 && bitcnt[k] < 64) begin
            dd = bitcnt[k] - 32;
            bb = fmem(cmd[k][23:0] + 24'(dd / 8));
            miso[k] = bb[7 - (dd % 8)];
          end
        end else begin
          if (!pcsb[k]) begin
            chk("sck_low_at_csb_rise", k, sck[k], 0);
            if (frm_q[k].size() == 0) fail("unexpected_frame", k);
            else begin
              fe = frm_q[k].pop_front();
              chk("frame", k, {cmd[k], 16'(lo_len[k]), mbad[k]}, fe);
            end
            hi_len[k] = 0;
            seen[k] = 1'b1;
          end
          hi_len[k]++;
        end
        pcsb[k] = csb[k];
        psck[k] = sck[k];
      end
    end
  end

  task automatic issue(input int k, input bit p, input logic [23:0] a, input int n);
    int got = 0;
    int c = 0;
    if (!p) begin r0a[k] = a; r0v[k] = 1'b1; end
    else    begin r1a[k] = a; r1v[k] = 1'b1; end
    while (got < n && c < 20000) begin
      @(negedge clk);
      c++;
      if ((!p && r0r[k]) || (p && r1r[k])) begin
        got++;
        @(posedge clk);
      end
    end
    #1;
    if (!p) r0v[k] = 1'b0; else r1v[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy[k] && rsp_q[k].size() == 0 && frm_q[k].size() == 0) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_tx(input int k, input bit p, input bit b2b, input logic [23:0] a, input logic [31:0] w);
    gnt_q[k].push_back({p, b2b});
    rsp_q[k].push_back({p, w});
    frm_q[k].push_back({8'h03, a, 16'(128 * cd_of(k)), 1'b0});
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin r0a[k] = '0; r1a[k] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Simultaneous requests after reset: port 0 first, then port 1 back-to-back.
    expect_tx(0, 1'b0, 1'b0, 24'h000000, 32'h59585B5A);
    expect_tx(0, 1'b1, 1'b1, 24'h000100, 32'h58595A5B);
    fork
      issue(0, 1'b0, 24'h000000, 1);
      issue(0, 1'b1, 24'h000100, 1);
    join
    wait_idle(0);

    // Fairness: both held for six grants -> 0,1,0,1,0,1.
    for (int i = 0; i < 3; i++) begin
      expect_tx(0, 1'b0, (i != 0), 24'h000020, 32'h79787B7A);
      expect_tx(0, 1'b1, 1'b1, 24'h000030, 32'h69686B6A);
    end
    fork
      issue(0, 1'b0, 24'h000020, 3);
      issue(0, 1'b1, 24'h000030, 3);
    join
    wait_idle(0);

    // Single read on port 0.
    expect_tx(0, 1'b0, 1'b0, 24'h000010, 32'h44332211);
    issue(0, 1'b0, 24'h000010, 1);
    wait_idle(0);

    // Port 1 alone, three times.
    for (int i = 0; i < 3; i++) expect_tx(0, 1'b1, (i != 0), 24'h000010, 32'h44332211);
    issue(0, 1'b1, 24'h000010, 3);
    wait_idle(0);

    // Port 0 pulses valid for one cycle while busy: nothing issued.
    expect_tx(0, 1'b1, 1'b0, 24'h000020, 32'h79787B7A);
    issue(0, 1'b1, 24'h000020, 1);
    repeat (20) @(posedge clk);
    #1 r0a[0] = 24'h555555; r0v[0] = 1'b1;
    @(posedge clk); #1 r0v[0] = 1'b0;
    wait_idle(0);
    repeat (10) @(posedge clk); #1;

    // Reset during the data phase, then a full fresh read on port 1.
    gnt_q[0].push_back(2'b00);
    issue(0, 1'b0, 24'h000010, 1);
    for (int c = 0; c < 3000 && bitcnt[0] < 40; c++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    expect_tx(0, 1'b1, 1'b0, 24'h000010, 32'h44332211);
    issue(0, 1'b1, 24'h000010, 1);
    wait_idle(0);

    // Timing sweep: CLK_DIV 1 and 4.
    expect_tx(1, 1'b0, 1'b0, 24'h000010, 32'h44332211);
    expect_tx(2, 1'b0, 1'b0, 24'h000010, 32'h44332211);
    fork
      issue(1, 1'b0, 24'h000010, 1);
      issue(2, 1'b0, 24'h000010, 1);
    join
    wait_idle(1);
    wait_idle(2);

    repeat (10) @(posedge clk);
    fin = 1'b1;
  end
endmodule
